// File: rtl/coreport_debounce_if.sv
// coreport_debounce_if: raw pin inputs and conditioned level/event outputs of the debouncer
interface coreport_debounce_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     pin_i;
    logic [CNT_WIDTH-1:0] threshold_i;
    logic [WIDTH-1:0]     bypass_i;
    logic [WIDTH-1:0]     level_o;
    logic [WIDTH-1:0]     rise_o;
    logic [WIDTH-1:0]     fall_o;
    logic                 change_o;
    modport master (output pin_i, threshold_i, bypass_i, input level_o, rise_o, fall_o, change_o);
    modport slave  (input pin_i, threshold_i, bypass_i, output level_o, rise_o, fall_o, change_o);
endinterface

// File: rtl/coreport_debounce.sv
// coreport_debounce: per-pin synchroniser plus runtime-threshold debouncer with rise/fall pulses
module coreport_debounce #(
    parameter int               WIDTH         = 8,
    parameter int               SYNC_STAGES   = 2,
    parameter int               CNT_WIDTH     = 16,
    parameter logic [WIDTH-1:0] INITIAL_LEVEL = '0
) (
    input logic                wb_clk,
    input logic                wb_rst,
    coreport_debounce_if.slave bus
);
    localparam logic [CNT_WIDTH:0] ONE = (CNT_WIDTH+1)'(1);
    logic [WIDTH-1:0]                r_sync [SYNC_STAGES];
    logic [WIDTH-1:0][CNT_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]                r_level, r_rise, r_fall;
    logic                            r_change;
    logic [WIDTH-1:0]                w_s, w_next, w_hit;
    logic [WIDTH-1:0][CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH:0]              w_thr;
    assign w_s   = r_sync[SYNC_STAGES-1];
    // A zero threshold behaves as one so a disagreement always needs at least one edge
    assign w_thr = (bus.threshold_i == '0) ? ONE : {1'b0, bus.threshold_i};
    always_comb begin
        w_hit      = '0;
        w_next     = r_level;
        w_cnt_next = '0;
        for (int n = 0; n < WIDTH; n++) begin
            w_hit[n]      = ({1'b0, r_cnt[n]} + ONE) >= w_thr;
            w_next[n]     = (bus.bypass_i[n] || w_hit[n]) ? w_s[n] : r_level[n];
            w_cnt_next[n] = (bus.bypass_i[n] || w_s[n] == r_level[n] || w_hit[n]) ? '0 : r_cnt[n] + CNT_WIDTH'(1);
        end
    end
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= INITIAL_LEVEL;
            r_cnt    <= '0;
            r_level  <= INITIAL_LEVEL;
            r_rise   <= '0;
            r_fall   <= '0;
            r_change <= 1'b0;
        end else begin
            r_sync[0] <= bus.pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_cnt    <= w_cnt_next;
            r_level  <= w_next;
            r_rise   <= w_next & ~r_level;
            r_fall   <= ~w_next & r_level;
            r_change <= |(w_next ^ r_level);
        end
    end
    assign bus.level_o  = r_level;
    assign bus.rise_o   = r_rise;
    assign bus.fall_o   = r_fall;
    assign bus.change_o = r_change;
endmodule

// File: doc/coreport_debounce.md
Name: coreport_debounce

Overview:
- Input conditioning stage that sits directly upstream of the CorePort GPIO peripheral's input path.
- Synchronises raw asynchronous pin levels into the wb_clk domain and debounces each pin independently with a runtime threshold.
- Presents clean levels plus one-cycle rise/fall event pulses for the port's data read and interrupt flag logic.
- Purely a pin-to-fabric stage; it has no bus interface of its own.

Parameters:
- WIDTH, 8, number of pins handled.
- SYNC_STAGES, 2, flip-flops in each pin's synchroniser chain; legal range 2..4.
- CNT_WIDTH, 16, width of each per-pin stability counter and of threshold_i.
- INITIAL_LEVEL, 0, WIDTH-bit reset value of the synchroniser chains and of level_o.

Ports:
- wb_clk  input  1  single system clock; all logic is on its rising edge.
- wb_rst  input  1  synchronous, active-high reset.
- pin_i  input  WIDTH  raw asynchronous pin levels.
- threshold_i  input  CNT_WIDTH  consecutive stable cycles required to accept a change; quasi-static.
- bypass_i  input  WIDTH  per-pin debounce bypass; 1 = the synchronised level passes straight through.
- level_o  output  WIDTH  debounced level, registered.
- rise_o  output  WIDTH  one-cycle pulse when level_o bit goes 0->1, registered.
- fall_o  output  WIDTH  one-cycle pulse when level_o bit goes 1->0, registered.
- change_o  output  1  OR of all rise_o and fall_o bits, registered (same cycle as the pulses).

Behaviour:
- Clocking and reset: one clock, wb_clk. Reset is synchronous and active-high on wb_rst.
- Reset values:
  - Synchroniser chains = INITIAL_LEVEL.
  - level_o = INITIAL_LEVEL.
  - All counters = 0.
  - rise_o = fall_o = 0; change_o = 0.
  - No edge pulses are generated on the first cycle after reset.
- Synchroniser: pin_i[n] passes through SYNC_STAGES flops. s[n] denotes the last stage.
- Effective threshold: T = max(threshold_i, 1). threshold_i = 0 behaves exactly as threshold_i = 1.
- Per-pin debounce (bypass_i[n] = 0), evaluated every edge:
  - s[n] == level_o[n]: cnt[n] <= 0; no change.
  - s[n] != level_o[n] and cnt[n]+1 >= T: level_o[n] <= s[n]; cnt[n] <= 0; the matching rise_o[n] or fall_o[n] is asserted for exactly one cycle.
  - Otherwise: cnt[n] <= cnt[n]+1.
- Comparison is >=, so lowering threshold_i mid-count commits on the next edge. Raising it mid-count extends the wait.
- The counter never exceeds T-1, so no wrap is possible. T = 2^CNT_WIDTH-1 is the largest legal value.
- Latency: a clean pin step that is stable from edge k appears on s at edge k+SYNC_STAGES (±1 for metastability). level_o updates at edge k+SYNC_STAGES+T.
- Glitches: a disagreement on s lasting fewer than T consecutive cycles is fully rejected. The counter restarts from 0 on the next disagreement.
- Bypass (bypass_i[n] = 1):
  - level_o[n] <= s[n] every edge; cnt[n] held at 0.
  - rise_o and fall_o are still generated from level_o transitions.
  - Toggling bypass_i mid-count clears the count. Debounced operation resumes from 0 when bypass_i returns to 0.
- Pulses: rise_o[n] and fall_o[n] are never both 1 and never held for two consecutive cycles. Consecutive pulses on one pin are separated by at least T cycles, or by 1 cycle in bypass.
- Pins are fully independent. Simultaneous commits on several pins give simultaneous pulses; change_o is a single cycle.
- Reset mid-count: all counts are discarded. No pulses are emitted on the reset cycle or the cycle after.

Test Plan:
- WIDTH=8, SYNC_STAGES=2, threshold_i=4, INITIAL_LEVEL=0; pin_i[0] steps 0->1 at edge 10 and holds -> level_o[0]=1 at edge 16; rise_o[0]=1 and change_o=1 for the cycle after edge 16 only.
- Same setup; pin_i[3] high for 3 cycles then low -> level_o stays 0x00, no pulses, cnt[3] returns to 0.
- threshold_i=0; pin_i[5] 0->1 -> level_o[5] changes at edge k+3, identical to threshold_i=1; then 1->0 -> fall_o[5] pulse once.
- threshold_i=100, bypass_i=0x80; pin_i[7] toggles every 2 cycles -> level_o[7] follows s with 1-cycle lag, alternating rise/fall pulses; other pins unaffected.
- threshold_i=50, pin_i[2] rises; at count 30 lower threshold_i to 10 -> commit on the next edge with a single rise_o[2] pulse.
- pin_i=0xFF held 20 cycles with threshold_i=40, then wb_rst for 1 cycle -> level_o=0x00, counters cleared, no pulses; after release, commit occurs 40 cycles after the counter restarts.
